// File: rtl/any1_issue_sched_if.sv
// rtl/any1_issue_sched_if.sv - ROB-to-dispatch bundle for any1_issue_sched
interface any1_issue_sched_if #(
    parameter int ROB_ENTRIES = 64,
    parameter int IDXW        = $clog2(ROB_ENTRIES),
    parameter int ISSUE_WIDTH = 2
);
    logic                        flush;
    logic [IDXW-1:0]             que;
    logic [ROB_ENTRIES-1:0]      rdy_vec;
    logic [ROB_ENTRIES-1:0]      mem_vec;
    logic [ROB_ENTRIES-1:0]      ldst_pend_vec;
    logic [ROB_ENTRIES-1:0]      fc_vec;
    logic [ROB_ENTRIES-1:0]      branch_vec;
    logic                        iss_ready;
    logic [ISSUE_WIDTH-1:0]      iss_valid;
    logic [ISSUE_WIDTH*IDXW-1:0] iss_idx;
    logic [ROB_ENTRIES-1:0]      wakeup_list;

    modport master (
        output flush, que, rdy_vec, mem_vec, ldst_pend_vec, fc_vec, branch_vec, iss_ready,
        input  iss_valid, iss_idx, wakeup_list
    );

    modport slave (
        input  flush, que, rdy_vec, mem_vec, ldst_pend_vec, fc_vec, branch_vec, iss_ready,
        output iss_valid, iss_idx, wakeup_list
    );
endinterface

// File: rtl/any1_issue_sched.sv
// rtl/any1_issue_sched.sv - multi-issue oldest-first ROB scheduler with history suppression
// Optional macro ANY1_SCHED_BRANCH_FIRST_EN puts eligible branches ahead of other entries.
module any1_issue_sched #(
    parameter int ROB_ENTRIES = 64,
    parameter int IDXW        = $clog2(ROB_ENTRIES),
    parameter int ISSUE_WIDTH = 2,
    parameter int HIST_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    any1_issue_sched_if.slave  bus
);
    logic [ISSUE_WIDTH-1:0] iss_valid_q, iss_valid_d;
    logic [IDXW-1:0]        iss_idx_q [ISSUE_WIDTH];
    logic [IDXW-1:0]        iss_idx_d [ISSUE_WIDTH];
    logic [ROB_ENTRIES-1:0] wakeup_q;
    logic [IDXW-1:0]        hist_idx_q [HIST_DEPTH];
    logic [IDXW-1:0]        hist_idx_d [HIST_DEPTH];
    logic [HIST_DEPTH-1:0]  hist_vld_q, hist_vld_d;
    logic [ISSUE_WIDTH-1:0] fire;
    logic                   load;
    logic [ROB_ENTRIES-1:0] blocked;
    logic [ROB_ENTRIES-1:0] elig_age;
    logic [ROB_ENTRIES-1:0] elig;
    logic [IDXW-1:0]        age_to_idx [ROB_ENTRIES];

    assign fire = iss_valid_q & {ISSUE_WIDTH{bus.iss_ready}};
    assign load = bus.iss_ready | ~|iss_valid_q;

    // Work in age order: position a holds ROB slot que+a, so position 0 is the oldest.
    always_comb begin
        for (int a = 0; a < ROB_ENTRIES; a++) begin
            age_to_idx[a] = bus.que + IDXW'(a);
        end
    end

    // Entries currently sitting in a port (including any firing this cycle) or in history.
    always_comb begin
        blocked = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (iss_valid_q[k]) blocked[iss_idx_q[k]] = 1'b1;
        end
        for (int h = 0; h < HIST_DEPTH; h++) begin
            if (hist_vld_q[h]) blocked[hist_idx_q[h]] = 1'b1;
        end
    end

    always_comb begin : elig_blk
        logic            fc_seen;
        logic            ls_seen;
        logic [IDXW-1:0] i;
        fc_seen  = 1'b0;
        ls_seen  = 1'b0;
        i        = '0;
        elig_age = '0;
        elig     = '0;
        for (int a = 0; a < ROB_ENTRIES; a++) begin
            i           = age_to_idx[a];
            elig_age[a] = bus.rdy_vec[i] & ~blocked[i] & ~fc_seen
                        & ~(bus.mem_vec[i] & ls_seen);
            elig[i]     = elig_age[a];
            fc_seen     = fc_seen | bus.fc_vec[i];
            ls_seen     = ls_seen | bus.ldst_pend_vec[i];
        end
    end

    // Each port takes the best remaining candidate; the later scan wins, so scans run young-to-old.
    always_comb begin : sel_blk
        logic [ROB_ENTRIES-1:0] rem;
        logic [IDXW-1:0]        pick;
        logic                   hit;
        rem         = elig_age;
        pick        = '0;
        hit         = 1'b0;
        iss_valid_d = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            hit  = 1'b0;
            pick = '0;
            for (int a = ROB_ENTRIES - 1; a >= 0; a--) begin
`ifdef ANY1_SCHED_BRANCH_FIRST_EN
                if (rem[a] && !bus.branch_vec[age_to_idx[a]]) begin
`else
                if (rem[a]) begin
`endif
                    hit  = 1'b1;
                    pick = IDXW'(a);
                end
            end
`ifdef ANY1_SCHED_BRANCH_FIRST_EN
            for (int a = ROB_ENTRIES - 1; a >= 0; a--) begin
                if (rem[a] && bus.branch_vec[age_to_idx[a]]) begin
                    hit  = 1'b1;
                    pick = IDXW'(a);
                end
            end
`endif
            iss_valid_d[k] = hit;
            iss_idx_d[k]   = age_to_idx[pick];
            if (hit) rem[pick] = 1'b0;
        end
    end

`ifndef ANY1_SCHED_BRANCH_FIRST_EN
    logic unused_branch;
    assign unused_branch = ^bus.branch_vec;
`endif

    // Firing ports enter the history in port order; the oldest slot falls off the end.
    always_comb begin
        hist_idx_d = hist_idx_q;
        hist_vld_d = hist_vld_q;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (fire[k]) begin
                for (int h = HIST_DEPTH - 1; h > 0; h--) begin
                    hist_idx_d[h] = hist_idx_d[h-1];
                    hist_vld_d[h] = hist_vld_d[h-1];
                end
                hist_idx_d[0] = iss_idx_q[k];
                hist_vld_d[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= '0;
            wakeup_q    <= '0;
            hist_vld_q  <= '0;
            for (int k = 0; k < ISSUE_WIDTH; k++) iss_idx_q[k] <= '0;
            for (int h = 0; h < HIST_DEPTH; h++) hist_idx_q[h] <= '0;
        end else if (bus.flush) begin
            iss_valid_q <= '0;
            wakeup_q    <= '0;
            hist_vld_q  <= '0;
        end else begin
            hist_idx_q <= hist_idx_d;
            hist_vld_q <= hist_vld_d;
            if (load) begin
                iss_valid_q <= iss_valid_d;
                iss_idx_q   <= iss_idx_d;
                wakeup_q    <= elig;
            end
        end
    end

    assign bus.iss_valid   = iss_valid_q;
    assign bus.wakeup_list = wakeup_q;
    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_idx
        assign bus.iss_idx[k*IDXW +: IDXW] = iss_idx_q[k];
    end
endmodule

// File: tb/tb_any1_issue_sched.sv
// tb/tb_any1_issue_sched.sv - directed and randomized checks of any1_issue_sched against an age-order model
module tb_any1_issue_sched;
    localparam int N  = 64;
    localparam int IW = 6;
    localparam int W  = 2;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    any1_issue_sched_if #(.ROB_ENTRIES(N), .IDXW(IW), .ISSUE_WIDTH(W)) bus ();
    any1_issue_sched #(.ROB_ENTRIES(N), .IDXW(IW), .ISSUE_WIDTH(W), .HIST_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] m_valid;
    int           m_idx [W];
    logic [N-1:0] m_wake;
    int           hist [$];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] port(int k);
        return 64'(bus.iss_idx[k*IW +: IW]);
    endfunction

    function automatic int age_of(int i);
        return (i - int'(bus.que) + N) % N;
    endfunction

    function automatic logic [N-1:0] model_elig();
        logic [N-1:0] e;
        bit           ok;
        e = '0;
        for (int i = 0; i < N; i++) begin
            ok = bus.rdy_vec[i];
            foreach (hist[h]) if (hist[h] == i) ok = 0;
            for (int k = 0; k < W; k++) if (m_valid[k] && m_idx[k] == i) ok = 0;
            for (int j = 0; j < N; j++) begin
                if (age_of(j) < age_of(i)) begin
                    if (bus.fc_vec[j]) ok = 0;
                    if (bus.mem_vec[i] && bus.ldst_pend_vec[j]) ok = 0;
                end
            end
            e[i] = ok;
        end
        return e;
    endfunction

    task automatic chk_model(string tag);
        chk({tag, ".valid"}, 64'(bus.iss_valid), 64'(m_valid));
        for (int k = 0; k < W; k++) begin
            if (m_valid[k]) chk({tag, ".idx"}, port(k), 64'(m_idx[k]));
        end
        chk({tag, ".wake"}, bus.wakeup_list, m_wake);
    endtask

    // Advance one clock: predict from the spec rules, then compare after the edge.
    task automatic step(string tag);
        logic [N-1:0] e;
        logic [W-1:0] nv;
        int           ni [W];
        int           n;
        int           i;
        e  = model_elig();
        nv = '0;
        n  = 0;
        for (int k = 0; k < W; k++) ni[k] = 0;
`ifdef ANY1_SCHED_BRANCH_FIRST_EN
        for (int a = 0; a < N; a++) begin
            i = (int'(bus.que) + a) % N;
            if (e[i] && bus.branch_vec[i] && n < W) begin nv[n] = 1'b1; ni[n] = i; n++; end
        end
        for (int a = 0; a < N; a++) begin
            i = (int'(bus.que) + a) % N;
            if (e[i] && !bus.branch_vec[i] && n < W) begin nv[n] = 1'b1; ni[n] = i; n++; end
        end
`else
        for (int a = 0; a < N; a++) begin
            i = (int'(bus.que) + a) % N;
            if (e[i] && n < W) begin nv[n] = 1'b1; ni[n] = i; n++; end
        end
`endif
        if (bus.flush) begin
            m_valid = '0;
            m_wake  = '0;
            hist.delete();
        end else begin
            for (int k = 0; k < W; k++) begin
                if (m_valid[k] && bus.iss_ready) begin
                    hist.push_back(m_idx[k]);
                    if (hist.size() > D) void'(hist.pop_front());
                end
            end
            if (bus.iss_ready || m_valid == '0) begin
                m_valid = nv;
                m_idx   = ni;
                m_wake  = e;
            end
        end
        @(posedge clk);
        #1;
        chk_model(tag);
    endtask

    task automatic clr_inputs();
        bus.flush         = 1'b0;
        bus.que           = '0;
        bus.rdy_vec       = '0;
        bus.mem_vec       = '0;
        bus.ldst_pend_vec = '0;
        bus.fc_vec        = '0;
        bus.branch_vec    = '0;
        bus.iss_ready     = 1'b1;
    endtask

    task automatic do_flush();
        clr_inputs();
        bus.flush = 1'b1;
        step("flush");
        bus.flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        clr_inputs();
        m_valid = '0;
        m_wake  = '0;
        for (int k = 0; k < W; k++) m_idx[k] = 0;

        // Reset state, then release away from a clock edge.
        #12;
        chk("reset.valid", 64'(bus.iss_valid), 64'd0);
        chk("reset.idx", 64'(bus.iss_idx), 64'd0);
        chk("reset.wake", bus.wakeup_list, 64'd0);
        bus.que = 6'd10;
        bus.rdy_vec[12] = 1'b1;
        bus.rdy_vec[40] = 1'b1;
        bus.rdy_vec[11] = 1'b1;
        rst_n = 1'b1;

        step("basic1");
        chk("basic1.v", 64'(bus.iss_valid), 64'b11);
        chk("basic1.p0", port(0), 64'd11);
        chk("basic1.p1", port(1), 64'd12);
        step("basic2");
        chk("basic2.v", 64'(bus.iss_valid), 64'b01);
        chk("basic2.p0", port(0), 64'd40);

        // Age order wraps past the top of the ROB.
        do_flush();
        bus.que = 6'd62;
        bus.rdy_vec[1]  = 1'b1;
        bus.rdy_vec[63] = 1'b1;
        step("wrap");
        chk("wrap.p0", port(0), 64'd63);
        chk("wrap.p1", port(1), 64'd1);

        do_flush();
        bus.ldst_pend_vec[5] = 1'b1;
        bus.mem_vec[7] = 1'b1;
        bus.rdy_vec[7] = 1'b1;
        step("mem_block");
        chk("mem_block.v", 64'(bus.iss_valid), 64'd0);
        bus.ldst_pend_vec[5] = 1'b0;
        step("mem_go");
        chk("mem_go.v", 64'(bus.iss_valid), 64'b01);
        chk("mem_go.p0", port(0), 64'd7);

        do_flush();
        bus.fc_vec[20] = 1'b1;
        bus.rdy_vec[25] = 1'b1;
        step("fc_block");
        chk("fc_block.v", 64'(bus.iss_valid), 64'd0);
        bus.fc_vec[20] = 1'b0;
        step("fc_go");
        chk("fc_go.p0", port(0), 64'd25);

        // Stall freezes outputs; fired indices stay suppressed by history.
        do_flush();
        bus.rdy_vec[2] = 1'b1;
        bus.rdy_vec[3] = 1'b1;
        step("stall_fill");
        bus.iss_ready = 1'b0;
        bus.rdy_vec[4] = 1'b1;
        step("stall1");
        bus.rdy_vec[5] = 1'b1;
        step("stall2");
        bus.rdy_vec[2] = 1'b0;
        step("stall3");
        chk("stall.v", 64'(bus.iss_valid), 64'b11);
        chk("stall.p0", port(0), 64'd2);
        chk("stall.p1", port(1), 64'd3);
        bus.rdy_vec[2] = 1'b1;
        bus.iss_ready = 1'b1;
        step("rel1");
        chk("rel1.p0", port(0), 64'd4);
        chk("rel1.p1", port(1), 64'd5);
        step("rel2");
        step("rel3");
        chk("hist_supp.v", 64'(bus.iss_valid), 64'd0);

        // Flush mid-stall clears history so a held index comes back.
        bus.rdy_vec = '0;
        bus.rdy_vec[6] = 1'b1;
        step("fl_fill");
        bus.iss_ready = 1'b0;
        step("fl_stall");
        bus.flush = 1'b1;
        step("fl_flush");
        chk("fl_flush.v", 64'(bus.iss_valid), 64'd0);
        bus.flush = 1'b0;
        bus.iss_ready = 1'b1;
        step("fl_again");
        chk("fl_again.p0", port(0), 64'd6);

        // Asynchronous reset while stalled.
        bus.iss_ready = 1'b0;
        bus.rdy_vec[9] = 1'b1;
        step("ar_stall");
        #2 rst_n = 1'b0;
        #1;
        chk("areset.valid", 64'(bus.iss_valid), 64'd0);
        chk("areset.idx", 64'(bus.iss_idx), 64'd0);
        chk("areset.wake", bus.wakeup_list, 64'd0);
        m_valid = '0;
        m_wake  = '0;
        hist.delete();
        #2 rst_n = 1'b1;
        bus.iss_ready = 1'b1;
        step("ar_first");
        chk("ar_first.v", 64'(bus.iss_valid), 64'b11);

        do_flush();
        bus.rdy_vec[3] = 1'b1;
        bus.rdy_vec[9] = 1'b1;
        bus.branch_vec[9] = 1'b1;
        step("brfirst");
`ifdef ANY1_SCHED_BRANCH_FIRST_EN
        chk("brfirst.p0", port(0), 64'd9);
        chk("brfirst.p1", port(1), 64'd3);
`else
        chk("brfirst.p0", port(0), 64'd3);
        chk("brfirst.p1", port(1), 64'd9);
`endif

        for (int it = 0; it < 400; it++) begin
            bus.que = IW'($urandom_range(0, N - 1));
            if ($urandom_range(0, 2) == 0)
                bus.rdy_vec = {$urandom, $urandom} & {$urandom, $urandom};
            bus.mem_vec       = {$urandom, $urandom};
            bus.branch_vec    = {$urandom, $urandom};
            bus.ldst_pend_vec = ($urandom_range(0, 3) == 0) ? (64'd1 << $urandom_range(0, N - 1)) : '0;
            bus.fc_vec        = ($urandom_range(0, 5) == 0) ? (64'd1 << $urandom_range(0, N - 1)) : '0;
            bus.iss_ready     = ($urandom_range(0, 3) != 0);
            bus.flush         = ($urandom_range(0, 24) == 0);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
